// File: rtl/prog_seq_pkg.sv
// Shared types and program address tables for the prog_sequencer run controller.
package prog_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_FINISH = 2'd3
  } seq_state_t;

  localparam int LOAD_CYCLES_DEF = 2;

  function automatic logic [15:0] prog_start(input logic [1:0] idx);
    case (idx)
      2'd0:    prog_start = 16'd0;
      2'd1:    prog_start = 16'd124;
      2'd2:    prog_start = 16'd301;
      default: prog_start = 16'd0;
    endcase
  endfunction

  function automatic logic [15:0] prog_end(input logic [1:0] idx);
    case (idx)
      2'd0:    prog_end = 16'd123;
      2'd1:    prog_end = 16'd300;
      2'd2:    prog_end = 16'd511;
      default: prog_end = 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/seq_cycle_ctr.sv
// Saturating RUN-cycle counter with clear/enable.
// PROG_SEQ_WATCHDOG_EN adds the TIMEOUT compare output (at_limit).
module seq_cycle_ctr #(
  parameter int CYC_W   = 24,
  parameter int TIMEOUT = 65535
) (
  input  logic             CLK,
  input  logic             Init,
  input  logic             clr,
  input  logic             en,
  output logic [CYC_W-1:0] count,
  output logic             at_limit
);

  always_ff @(posedge CLK or posedge Init) begin
    if (Init)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en && (count != '1))
      count <= count + 1'b1;
  end

`ifdef PROG_SEQ_WATCHDOG_EN
  // Fires in the RUN cycle whose increment makes count reach TIMEOUT.
  assign at_limit = en && (count == CYC_W'(TIMEOUT - 1));
`else
  assign at_limit = 1'b0;
`endif

endmodule

// File: rtl/prog_sequencer.sv
// Run controller: loads a program start PC into the fetch unit, monitors the run,
// reports completion via Req/Done handshake. Optional watchdog: PROG_SEQ_WATCHDOG_EN.
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int NUM_PROGS   = 3,
  parameter int PC_W        = 16,
  parameter int CYC_W       = 24,
  parameter int LOAD_CYCLES = LOAD_CYCLES_DEF,
  parameter int TIMEOUT     = 65535
) (
  input  logic             CLK,
  input  logic             Init,
  input  logic             Req,
  input  logic [1:0]       Prog_sel,
  input  logic [PC_W-1:0]  PC,
  input  logic             Core_done,
  output logic             Ack,
  output logic             Bad_sel,
  output logic             Core_init,
  output logic [PC_W-1:0]  Start_pc,
  output logic             Run,
  output logic             Done,
  output logic             Timeout,
  output logic [CYC_W-1:0] Cycles
);

  // state  | meaning
  // IDLE   | waiting for Req
  // LOAD   | Core_init held, fetch unit loads Start_pc
  // RUN    | core enabled, counting cycles
  // FINISH | Done high until Req falls

  localparam int LD_W = $clog2(LOAD_CYCLES + 1);

  seq_state_t      state, state_nxt;
  logic [1:0]      sel_q;
  logic [LD_W-1:0] load_cnt;
  logic            bad_lock;
  logic            sel_legal, accept, reject;
  logic            end_hit, wd_hit, run_stop, load_tc;

  assign sel_legal = (int'(Prog_sel) < NUM_PROGS);
  assign accept    = (state == ST_IDLE) && Req && sel_legal;
  assign reject    = (state == ST_IDLE) && Req && !sel_legal && !bad_lock;
  assign end_hit   = (PC == PC_W'(prog_end(sel_q)));
  assign run_stop  = Core_done || end_hit || wd_hit;
  assign load_tc   = (load_cnt == '0);
  assign Start_pc  = PC_W'(prog_start(sel_q));

  always_ff @(posedge CLK or posedge Init) begin
    if (Init)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept)   state_nxt = ST_LOAD;
      ST_LOAD:   if (load_tc)  state_nxt = ST_RUN;
      ST_RUN:    if (run_stop) state_nxt = ST_FINISH;
      ST_FINISH: if (!Req)     state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    Core_init = 1'b0;
    Run       = 1'b0;
    Done      = 1'b0;
    case (state)
      ST_LOAD:   Core_init = 1'b1;
      ST_RUN:    Run       = 1'b1;
      ST_FINISH: Done      = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge Init) begin
    if (Init) begin
      sel_q    <= 2'd0;
      load_cnt <= '0;
      Ack      <= 1'b0;
      Bad_sel  <= 1'b0;
      bad_lock <= 1'b0;
    end else begin
      Ack     <= accept;
      Bad_sel <= reject;
      if (accept)
        sel_q <= Prog_sel;
      // one Bad_sel per Req assertion
      if (!Req)
        bad_lock <= 1'b0;
      else if (reject)
        bad_lock <= 1'b1;
      if (accept)
        load_cnt <= LD_W'(LOAD_CYCLES - 1);
      else if ((state == ST_LOAD) && !load_tc)
        load_cnt <= load_cnt - 1'b1;
    end
  end

  seq_cycle_ctr #(
    .CYC_W   (CYC_W),
    .TIMEOUT (TIMEOUT)
  ) u_cycle_ctr (
    .CLK      (CLK),
    .Init     (Init),
    .clr      (accept),
    .en       (state == ST_RUN),
    .count    (Cycles),
    .at_limit (wd_hit)
  );

`ifdef PROG_SEQ_WATCHDOG_EN
  logic timeout_q;

  // Core_done or PROG_END in the same cycle takes priority over the watchdog.
  always_ff @(posedge CLK or posedge Init) begin
    if (Init)
      timeout_q <= 1'b0;
    else if (accept)
      timeout_q <= 1'b0;
    else if ((state == ST_RUN) && wd_hit && !Core_done && !end_hit)
      timeout_q <= 1'b1;
  end

  assign Timeout = timeout_q;
`else
  assign Timeout = 1'b0;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: directed scenarios plus randomized runs
// checked against an event-based run model.
module tb_prog_sequencer;

`ifdef PROG_SEQ_WATCHDOG_EN
  localparam bit WD_EN      = 1'b1;
  localparam int TB_TIMEOUT = 20;
`else
  localparam bit WD_EN      = 1'b0;
  localparam int TB_TIMEOUT = 65535;
`endif

  localparam int PC_W  = 16;
  localparam int CYC_W = 24;

  logic             CLK = 1'b0;
  logic             Init;
  logic             Req;
  logic [1:0]       Prog_sel;
  logic [PC_W-1:0]  PC;
  logic             Core_done;
  logic             Ack, Bad_sel, Core_init, Run, Done, Timeout;
  logic [PC_W-1:0]  Start_pc;
  logic [CYC_W-1:0] Cycles;

  int errors = 0;
  int checks = 0;

  int start_tab [0:2] = '{0, 124, 301};
  int end_tab   [0:2] = '{123, 300, 511};

  prog_sequencer #(
    .NUM_PROGS   (3),
    .PC_W        (PC_W),
    .CYC_W       (CYC_W),
    .LOAD_CYCLES (2),
    .TIMEOUT     (TB_TIMEOUT)
  ) dut (
    .CLK       (CLK),
    .Init      (Init),
    .Req       (Req),
    .Prog_sel  (Prog_sel),
    .PC        (PC),
    .Core_done (Core_done),
    .Ack       (Ack),
    .Bad_sel   (Bad_sel),
    .Core_init (Core_init),
    .Start_pc  (Start_pc),
    .Run       (Run),
    .Done      (Done),
    .Timeout   (Timeout),
    .Cycles    (Cycles)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Run ends at the earliest terminating event; watchdog loses ties.
  task automatic model(input int done_at, input int pcend_at, output int n, output bit to);
    int big, ev, wd;
    big = 1 << 30;
    ev  = big;
    if (done_at  > 0 && done_at  < ev) ev = done_at;
    if (pcend_at > 0 && pcend_at < ev) ev = pcend_at;
    wd = WD_EN ? TB_TIMEOUT : big;
    if (wd < ev) begin n = wd; to = 1'b1; end
    else         begin n = ev; to = 1'b0; end
  endtask

  // One complete request; drop_at = RUN cycle in which Req falls (0 = hold into FINISH).
  task automatic do_run(input int sel, input int done_at, input int pcend_at,
                        input int drop_at, input int hold);
    int  n;
    bit  to;
    bit  req_low;
    model(done_at, pcend_at, n, to);
    req_low   = 1'b0;
    Req       = 1'b1;
    Prog_sel  = 2'(sel);
    PC        = PC_W'(start_tab[sel]);
    Core_done = 1'b0;
    tick;
    check("ack_first_load", {31'b0, Ack}, 32'd1);
    check("init_first_load", {31'b0, Core_init}, 32'd1);
    check("start_pc_load", {16'b0, Start_pc}, 32'(start_tab[sel]));
    check("cycles_cleared", {8'b0, Cycles}, 32'd0);
    tick;
    check("ack_pulse_end", {31'b0, Ack}, 32'd0);
    check("init_second_load", {31'b0, Core_init}, 32'd1);
    tick;
    check("init_fall_run", {31'b0, Core_init}, 32'd0);
    check("run_high", {31'b0, Run}, 32'd1);
    for (int j = 1; j <= n; j++) begin
      Core_done = (j == done_at);
      PC = (j == pcend_at) ? PC_W'(end_tab[sel]) : PC_W'(start_tab[sel] + j);
      if (j == drop_at) begin Req = 1'b0; req_low = 1'b1; end
      tick;
    end
    Core_done = 1'b0;
    PC        = PC_W'(start_tab[sel]);
    check("done_high", {31'b0, Done}, 32'd1);
    check("run_low_finish", {31'b0, Run}, 32'd0);
    check("cycles_final", {8'b0, Cycles}, 32'(n));
    check("timeout_flag", {31'b0, Timeout}, {31'b0, to});
    if (!req_low) begin
      for (int k = 0; k < hold; k++) begin
        tick;
        check("done_held", {31'b0, Done}, 32'd1);
        check("no_rerun_ack", {31'b0, Ack}, 32'd0);
      end
      Req = 1'b0;
    end
    tick;
    check("done_drop", {31'b0, Done}, 32'd0);
    check("idle_no_init", {31'b0, Core_init}, 32'd0);
    tick;
    check("idle_no_ack", {31'b0, Ack}, 32'd0);
  endtask

  initial begin
    int sel, d, p, dr;
    Init = 1'b1; Req = 1'b0; Prog_sel = 2'd0; PC = '0; Core_done = 1'b0;
    #12;
    check("rst_start_pc", {16'b0, Start_pc}, 32'd0);
    check("rst_outputs", {26'b0, Ack, Bad_sel, Core_init, Run, Done, Timeout}, 32'd0);
    check("rst_cycles", {8'b0, Cycles}, 32'd0);
    Init = 1'b0;
    tick;

    // Reset asserted in the middle of a RUN of program 1.
    Req = 1'b1; Prog_sel = 2'd1; PC = 16'd124;
    tick; tick; tick; tick; tick;
    check("pre_abort_run", {31'b0, Run}, 32'd1);
    #2 Init = 1'b1;
    #1;
    check("abort_outputs", {26'b0, Ack, Bad_sel, Core_init, Run, Done, Timeout}, 32'd0);
    check("abort_start_pc", {16'b0, Start_pc}, 32'd0);
    check("abort_cycles", {8'b0, Cycles}, 32'd0);
    Req = 1'b0;
    tick;
    Init = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick;
      check("no_done_after_abort", {30'b0, Done, Run}, 32'd0);
    end

    do_run(1, 10, 0, 0, 0);
    do_run(2, 0, 5, 0, 0);
    do_run(0, 7, 7, 0, 0);
    do_run(1, 4, 0, 0, 5);
    do_run(2, 6, 0, 3, 0);

    // Illegal selection: single Bad_sel per Req assertion.
    Req = 1'b1; Prog_sel = 2'd3;
    tick;
    check("bad_sel_pulse", {31'b0, Bad_sel}, 32'd1);
    check("bad_sel_no_ack", {31'b0, Ack}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick;
      check("bad_sel_once", {29'b0, Bad_sel, Ack, Core_init}, 32'd0);
    end
    Req = 1'b0;
    tick;
    Req = 1'b1;
    tick;
    check("bad_sel_reflag", {31'b0, Bad_sel}, 32'd1);
    Req = 1'b0;
    tick; tick;

    if (WD_EN) begin
      do_run(0, 0, 0, 0, 0);
      do_run(1, TB_TIMEOUT, 0, 0, 0);
    end

    for (int r = 0; r < 8; r++) begin
      sel = int'($urandom_range(0, 2));
      d   = int'($urandom_range(1, 30));
      p   = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 30));
      dr  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      do_run(sel, d, p, dr, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
